clk_trig_decoder: RTL

Receive-side decoder for the combined clock/trigger line produced by our clock-and-trigger encoders. Oversamples the incoming line on `fastclk`, recovers a per-period clock strobe, measures period and high time, and decodes the embedded trigger. Two schemes are supported: duty-cycle (25% high = trigger 1, 75% high = trigger 0) and gated-clock (missing pulses = trigger 1). Sits at the SMA input of the receiving board and feeds downstream capture logic.

---
 rtl/clk_trig_decoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/clk_trig_decoder.sv
// Receive-side decoder for a combined clock/trigger line: recovers a per-period
// strobe, tracks the line period and decodes duty-cycle or gated-clock triggers.
module clk_trig_decoder #(
    parameter int CNT_W        = 8,
    parameter int LOCK_PERIODS = 2
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic             mode,
    input  logic             line_in,
    output logic             rec_clk,
    output logic             trig_out,
    output logic             trig_valid,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             err
);
    localparam int                GOOD_W    = $clog2(LOCK_PERIODS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_PERIODS);

    typedef enum logic [1:0] {
        ST_UNLOCK,
        ST_ACQ,
        ST_LOCKED
    } state_t;

    logic              s1_reg, s2_reg, s3_reg;
    logic              rise, fall;
    logic [CNT_W-1:0]  per_cnt_reg, hi_cnt_reg, hi_len_reg;
    logic              mode_reg;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  ref_reg, ref_next;
    logic [GOOD_W-1:0] good_reg, good_next, good_inc;
    logic [CNT_W-1:0]  period_reg, period_next;
    logic              trig_out_reg, trig_out_next;
    logic              trig_valid_reg, trig_valid_next;
    logic              err_reg, err_next;
    logic              to_flag_reg, to_flag_next;

    logic [CNT_W:0]    p_ext, ref_ext, diff, thr, hi2;
    logic              in_tol, timeout_hit, short_hi, per_sat;

    assign rise = s2_reg & ~s3_reg;
    assign fall = ~s2_reg & s3_reg;

    always_ff @(posedge fastclk) begin
        if (reset) begin
            s1_reg      <= 1'b0;
            s2_reg      <= 1'b0;
            s3_reg      <= 1'b0;
            per_cnt_reg <= '0;
            hi_cnt_reg  <= '0;
            hi_len_reg  <= '0;
            mode_reg    <= 1'b0;
        end else begin
            s1_reg   <= line_in;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            mode_reg <= mode;
            if (rise)
                per_cnt_reg <= CNT_ONE;
            else if (per_cnt_reg != CNT_MAX)
                per_cnt_reg <= per_cnt_reg + CNT_ONE;
            if (rise)
                hi_cnt_reg <= CNT_ONE;
            else if (s2_reg && hi_cnt_reg != CNT_MAX)
                hi_cnt_reg <= hi_cnt_reg + CNT_ONE;
            if (fall)
                hi_len_reg <= hi_cnt_reg;
        end
    end

    // Period arithmetic is one bit wider than the counters so nothing wraps.
    assign p_ext       = {1'b0, per_cnt_reg};
    assign ref_ext     = {1'b0, ref_reg};
    assign diff        = (p_ext >= ref_ext) ? (p_ext - ref_ext) : (ref_ext - p_ext);
    assign in_tol      = (diff <= (ref_ext >> 2));
    assign thr         = ref_ext + (ref_ext >> 1);
    assign hi2         = {hi_len_reg, 1'b0};
    assign short_hi    = (hi2 < p_ext);
    assign per_sat     = (per_cnt_reg == CNT_MAX);
    assign timeout_hit = (p_ext == thr) || per_sat;
    assign good_inc    = good_reg + GOOD_ONE;

    always_ff @(posedge fastclk) begin
        if (reset) begin
            state_reg      <= ST_UNLOCK;
            ref_reg        <= '0;
            good_reg       <= '0;
            period_reg     <= '0;
            trig_out_reg   <= 1'b0;
            trig_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
            to_flag_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ref_reg        <= ref_next;
            good_reg       <= good_next;
            period_reg     <= period_next;
            trig_out_reg   <= trig_out_next;
            trig_valid_reg <= trig_valid_next;
            err_reg        <= err_next;
            to_flag_reg    <= to_flag_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ref_next        = ref_reg;
        good_next       = good_reg;
        period_next     = period_reg;
        trig_out_next   = trig_out_reg;
        trig_valid_next = 1'b0;
        err_next        = 1'b0;
        to_flag_next    = to_flag_reg;

        if (mode != mode_reg) begin
            // A scheme change invalidates everything learned so far.
            state_next    = ST_UNLOCK;
            trig_out_next = 1'b0;
            period_next   = '0;
            to_flag_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_UNLOCK: begin
                    if (rise) begin
                        state_next   = ST_ACQ;
                        ref_next     = '0;
                        good_next    = '0;
                        to_flag_next = 1'b0;
                    end
                end
                ST_ACQ: begin
                    if (rise) begin
                        ref_next = per_cnt_reg;
                        if (good_reg == '0 || in_tol)
                            good_next = good_inc;
                        else
                            good_next = GOOD_ONE;
                        if (good_next == GOOD_LOCK) begin
                            state_next  = ST_LOCKED;
                            period_next = per_cnt_reg;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!mode_reg) begin
                        if (rise) begin
                            if (in_tol) begin
                                ref_next        = per_cnt_reg;
                                period_next     = per_cnt_reg;
                                trig_out_next   = short_hi;
                                trig_valid_next = 1'b1;
                            end else begin
                                err_next      = 1'b1;
                                state_next    = ST_UNLOCK;
                                trig_out_next = 1'b0;
                            end
                        end else if (per_sat) begin
                            err_next      = 1'b1;
                            state_next    = ST_UNLOCK;
                            trig_out_next = 1'b0;
                        end
                    end else begin
                        if (rise) begin
                            trig_out_next   = 1'b0;
                            trig_valid_next = 1'b1;
                            to_flag_next    = 1'b0;
                            // A period stretched by missing pulses is not a period sample.
                            if (!to_flag_reg) begin
                                if (in_tol) begin
                                    ref_next    = per_cnt_reg;
                                    period_next = per_cnt_reg;
                                end else begin
                                    err_next   = 1'b1;
                                    state_next = ST_UNLOCK;
                                end
                            end
                        end else if (!to_flag_reg && timeout_hit) begin
                            trig_out_next   = 1'b1;
                            trig_valid_next = 1'b1;
                            to_flag_next    = 1'b1;
                        end
                    end
                end
                default: state_next = ST_UNLOCK;
            endcase
        end
    end

    assign rec_clk    = rise;
    assign trig_out   = trig_out_reg;
    assign trig_valid = trig_valid_reg;
    assign period     = period_reg;
    assign locked     = (state_reg == ST_LOCKED);
    assign err        = err_reg;

endmodule
